// File: rtl/writeback_stage.sv
// MEM/WB pipeline register with load-data formatting and the writeback result select.
// Register-file write port and the forwarding result both come from registered state only.
module writeback_stage #(
  parameter int unsigned WIDTH      = 32,
  parameter int unsigned ADDR_WIDTH = 5
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  StallW,
  input  logic                  FlushW,
  input  logic [WIDTH-1:0]      ALUResultM,
  input  logic [WIDTH-1:0]      ReadDataM,
  input  logic [WIDTH-1:0]      PCPlus4M,
  input  logic [WIDTH-1:0]      ImmExtM,
  input  logic [1:0]            ResultSrcM,
  input  logic [2:0]            LoadTypeM,
  input  logic                  RegWriteM,
  input  logic [ADDR_WIDTH-1:0] RdM,
  output logic [WIDTH-1:0]      ResultW,
  output logic [ADDR_WIDTH-1:0] RdW,
  output logic                  RegWriteW,
  output logic                  ValidW
);

  localparam logic [2:0] LtLb  = 3'b000;
  localparam logic [2:0] LtLh  = 3'b001;
  localparam logic [2:0] LtLw  = 3'b010;
  localparam logic [2:0] LtLbu = 3'b100;
  localparam logic [2:0] LtLhu = 3'b101;

  logic [WIDTH-1:0]      alu_q, rdata_q, pc4_q, imm_q;
  logic [1:0]            src_q;
  logic [2:0]            ltype_q;
  logic                  regwrite_q;
  logic [ADDR_WIDTH-1:0] rd_q;
  logic                  valid_q;

  // A flush only kills the valid/write bits; data fields are held so ResultW stays stable.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      alu_q      <= '0;
      rdata_q    <= '0;
      pc4_q      <= '0;
      imm_q      <= '0;
      src_q      <= '0;
      ltype_q    <= '0;
      regwrite_q <= 1'b0;
      rd_q       <= '0;
      valid_q    <= 1'b0;
    end else if (FlushW) begin
      regwrite_q <= 1'b0;
      valid_q    <= 1'b0;
    end else if (!StallW) begin
      alu_q      <= ALUResultM;
      rdata_q    <= ReadDataM;
      pc4_q      <= PCPlus4M;
      imm_q      <= ImmExtM;
      src_q      <= ResultSrcM;
      ltype_q    <= LoadTypeM;
      regwrite_q <= RegWriteM;
      rd_q       <= RdM;
      valid_q    <= 1'b1;
    end
  end

  logic [1:0]       off;
  logic [7:0]       byte_sel;
  logic [15:0]      half_sel;
  logic [WIDTH-1:0] load_val;

  assign off = alu_q[1:0];

  always_comb begin
    byte_sel = 8'h00;
    unique case (off)
      2'd0: byte_sel = rdata_q[7:0];
      2'd1: byte_sel = rdata_q[15:8];
      2'd2: byte_sel = rdata_q[23:16];
      2'd3: byte_sel = rdata_q[31:24];
      default: byte_sel = 8'h00;
    endcase
    half_sel = off[1] ? rdata_q[31:16] : rdata_q[15:0];
  end

  always_comb begin
    load_val = '0;
    case (ltype_q)
      LtLb:    load_val = WIDTH'($signed(byte_sel));
      LtLh:    load_val = WIDTH'($signed(half_sel));
      LtLw:    load_val = WIDTH'($signed(rdata_q[31:0]));
      LtLbu:   load_val = WIDTH'(byte_sel);
      LtLhu:   load_val = WIDTH'(half_sel);
      default: load_val = '0;
    endcase
  end

  always_comb begin
    ResultW = '0;
    unique case (src_q)
      2'd0: ResultW = alu_q;
      2'd1: ResultW = load_val;
      2'd2: ResultW = pc4_q;
      2'd3: ResultW = imm_q;
      default: ResultW = '0;
    endcase
  end

  assign RdW       = rd_q;
  assign ValidW    = valid_q;
  assign RegWriteW = regwrite_q & valid_q & (rd_q != '0);

endmodule

// File: tb/tb_writeback_stage.sv
// Directed bench for writeback_stage: a behavioural W-stage model checked every cycle,
// plus literal expectations taken straight from the load/mux/stall/reset scenarios.
module tb_writeback_stage;

  logic        clk = 1'b0;
  logic        rst;
  logic        StallW, FlushW;
  logic [31:0] ALUResultM, ReadDataM, PCPlus4M, ImmExtM;
  logic [1:0]  ResultSrcM;
  logic [2:0]  LoadTypeM;
  logic        RegWriteM;
  logic [4:0]  RdM;
  logic [31:0] ResultW;
  logic [4:0]  RdW;
  logic        RegWriteW, ValidW;

  int n_cmp = 0;
  int n_fail = 0;
  bit chk_en = 1'b0;

  writeback_stage #(.WIDTH(32), .ADDR_WIDTH(5)) dut (
    .clk        (clk),
    .rst        (rst),
    .StallW     (StallW),
    .FlushW     (FlushW),
    .ALUResultM (ALUResultM),
    .ReadDataM  (ReadDataM),
    .PCPlus4M   (PCPlus4M),
    .ImmExtM    (ImmExtM),
    .ResultSrcM (ResultSrcM),
    .LoadTypeM  (LoadTypeM),
    .RegWriteM  (RegWriteM),
    .RdM        (RdM),
    .ResultW    (ResultW),
    .RdW        (RdW),
    .RegWriteW  (RegWriteW),
    .ValidW     (ValidW)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  // Load result by shifting the word and sign-extending with plain integer arithmetic.
  function automatic logic [31:0] model_load(input logic [31:0] word, input logic [31:0] addr,
                                             input logic [2:0] f3);
    longint v;
    int unsigned off;
    off = addr % 4;
    case (f3)
      3'b000: begin v = (longint'(word) >> (8 * off)) & 255;          if (v >= 128) v -= 256; end
      3'b001: begin v = (longint'(word) >> (16 * (off / 2))) & 65535; if (v >= 32768) v -= 65536; end
      3'b010: v = longint'(word);
      3'b100: v = (longint'(word) >> (8 * off)) & 255;
      3'b101: v = (longint'(word) >> (16 * (off / 2))) & 65535;
      default: v = 0;
    endcase
    return v[31:0];
  endfunction

  logic        m_valid = 1'b0;
  logic        m_rw = 1'b0;
  logic [4:0]  m_rd = '0;
  logic [31:0] m_result = '0;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_valid = 1'b0; m_rw = 1'b0; m_rd = '0; m_result = '0;
    end else if (FlushW) begin
      m_valid = 1'b0; m_rw = 1'b0;
    end else if (!StallW) begin
      m_valid = 1'b1;
      m_rw    = RegWriteM;
      m_rd    = RdM;
      case (ResultSrcM)
        2'd0: m_result = ALUResultM;
        2'd1: m_result = model_load(ReadDataM, ALUResultM, LoadTypeM);
        2'd2: m_result = PCPlus4M;
        default: m_result = ImmExtM;
      endcase
    end
  end

  always @(negedge clk) begin
    if (chk_en && !rst) begin
      logic exp_we;
      exp_we = m_valid && m_rw && (m_rd != 0);
      chk("model ValidW", 32'(ValidW), 32'(m_valid));
      chk("model RegWriteW", 32'(RegWriteW), 32'(exp_we));
      if (m_valid) chk("model RdW", 32'(RdW), 32'(m_rd));
      if (exp_we) chk("model ResultW", ResultW, m_result);
    end
  end

  task automatic drive(input logic [1:0] src, input logic [2:0] lt, input logic rw,
                       input logic [4:0] rd, input logic [31:0] alu, input logic [31:0] rdata,
                       input logic [31:0] pc4, input logic [31:0] imm);
    ResultSrcM = src; LoadTypeM = lt; RegWriteM = rw; RdM = rd;
    ALUResultM = alu; ReadDataM = rdata; PCPlus4M = pc4; ImmExtM = imm;
  endtask

  task automatic cycle();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b1; StallW = 1'b0; FlushW = 1'b0;
    drive(2'd0, 3'b010, 1'b0, 5'd0, 32'h0, 32'h0, 32'h0, 32'h0);
    repeat (2) @(posedge clk);
    #1;
    chk("reset ValidW", 32'(ValidW), 32'h0);
    chk("reset RegWriteW", 32'(RegWriteW), 32'h0);
    chk("reset RdW", 32'(RdW), 32'h0);
    chk("reset ResultW", ResultW, 32'h0);
    rst = 1'b0;
    chk_en = 1'b1;

    // Source mux
    drive(2'd0, 3'b010, 1'b1, 5'd5, 32'h11, 32'h0, 32'h104, 32'h12345000);
    cycle();
    chk("mux alu", ResultW, 32'h11);
    chk("mux alu rd", 32'(RdW), 32'd5);
    ResultSrcM = 2'd2;
    cycle();
    chk("mux pc4", ResultW, 32'h104);
    chk("mux pc4 rd", 32'(RdW), 32'd5);
    ResultSrcM = 2'd3;
    cycle();
    chk("mux imm", ResultW, 32'h12345000);
    chk("mux imm we", 32'(RegWriteW), 32'h1);

    // Load formatting
    drive(2'd1, 3'b000, 1'b1, 5'd7, 32'h1001, 32'h8081F2F3, 32'h0, 32'h0);
    cycle();
    chk("load lb", ResultW, 32'hFFFFFFF2);
    drive(2'd1, 3'b100, 1'b1, 5'd7, 32'h1003, 32'h8081F2F3, 32'h0, 32'h0);
    cycle();
    chk("load lbu", ResultW, 32'h00000080);
    drive(2'd1, 3'b001, 1'b1, 5'd7, 32'h1002, 32'h8081F2F3, 32'h0, 32'h0);
    cycle();
    chk("load lh", ResultW, 32'hFFFF8081);
    drive(2'd1, 3'b101, 1'b1, 5'd7, 32'h1000, 32'h8081F2F3, 32'h0, 32'h0);
    cycle();
    chk("load lhu", ResultW, 32'h0000F2F3);
    drive(2'd1, 3'b010, 1'b1, 5'd7, 32'h1000, 32'h8081F2F3, 32'h0, 32'h0);
    cycle();
    chk("load lw", ResultW, 32'h8081F2F3);
    drive(2'd1, 3'b011, 1'b1, 5'd7, 32'h1000, 32'h8081F2F3, 32'h0, 32'h0);
    cycle();
    chk("load reserved", ResultW, 32'h0);

    // x0 guard
    drive(2'd0, 3'b010, 1'b1, 5'd0, 32'hDEAD, 32'h0, 32'h0, 32'h0);
    cycle();
    chk("x0 we", 32'(RegWriteW), 32'h0);
    chk("x0 valid", 32'(ValidW), 32'h1);

    // Stall holds, then flush beats stall
    drive(2'd0, 3'b010, 1'b1, 5'd9, 32'hA5A5, 32'h0, 32'h0, 32'h0);
    cycle();
    StallW = 1'b1;
    for (int i = 0; i < 3; i++) begin
      drive(2'd2, 3'b000, 1'b1, 5'(i + 10), 32'(i), 32'hFFFF, 32'(i + 100), 32'h0);
      cycle();
      chk("stall result", ResultW, 32'hA5A5);
      chk("stall rd", 32'(RdW), 32'd9);
      chk("stall we", 32'(RegWriteW), 32'h1);
    end
    FlushW = 1'b1;
    cycle();
    chk("flush valid", 32'(ValidW), 32'h0);
    chk("flush we", 32'(RegWriteW), 32'h0);
    FlushW = 1'b0; StallW = 1'b0;

    // Back-to-back
    drive(2'd0, 3'b010, 1'b1, 5'd1, 32'h100, 32'h0, 32'h0, 32'h0);
    cycle();
    chk("b2b 1 data", ResultW, 32'h100);
    chk("b2b 1 rd", 32'(RdW), 32'd1);
    drive(2'd2, 3'b010, 1'b1, 5'd2, 32'h0, 32'h0, 32'h208, 32'h0);
    cycle();
    chk("b2b 2 data", ResultW, 32'h208);
    chk("b2b 2 rd", 32'(RdW), 32'd2);
    drive(2'd3, 3'b010, 1'b1, 5'd3, 32'h0, 32'h0, 32'h0, 32'hABCDE000);
    cycle();
    chk("b2b 3 data", ResultW, 32'hABCDE000);
    chk("b2b 3 rd", 32'(RdW), 32'd3);
    drive(2'd1, 3'b100, 1'b1, 5'd4, 32'h3, 32'h8081F2F3, 32'h0, 32'h0);
    cycle();
    chk("b2b 4 data", ResultW, 32'h80);
    chk("b2b 4 rd", 32'(RdW), 32'd4);
    chk("b2b 4 we", 32'(RegWriteW), 32'h1);

    // Asynchronous reset mid-cycle
    #2 rst = 1'b1;
    #1;
    chk("async rst ValidW", 32'(ValidW), 32'h0);
    chk("async rst RegWriteW", 32'(RegWriteW), 32'h0);
    chk("async rst RdW", 32'(RdW), 32'h0);
    chk("async rst ResultW", ResultW, 32'h0);
    #2 rst = 1'b0;
    cycle();
    chk("post rst valid", 32'(ValidW), 32'h1);
    chk("post rst data", ResultW, 32'h80);
    cycle();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
